// File: rtl/l15_req_arbiter.sv
// Shares the single L1.5 request/response port between fetch (port 0) and the memory wrapper (port 1).
// One transaction in flight: grant in IDLE, hold request until header ack, wait for response, route it back.
module l15_req_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        nrst,

  input  logic        req0_val,
  input  logic [3:0]  req0_rqtype,
  input  logic [2:0]  req0_size,
  input  logic [31:0] req0_address,
  input  logic [31:0] req0_data,
  output logic        req0_grant,
  output logic        resp0_val,

  input  logic        req1_val,
  input  logic [3:0]  req1_rqtype,
  input  logic [2:0]  req1_size,
  input  logic [31:0] req1_address,
  input  logic [31:0] req1_data,
  output logic        req1_grant,
  output logic        resp1_val,

  output logic [63:0] resp_data_0,
  output logic [63:0] resp_data_1,
  output logic [3:0]  resp_returntype,
  output logic        timeout_err,
  output logic        err_port,
  output logic        busy,

  output logic [3:0]  mem_l15_rqtype,
  output logic [2:0]  mem_l15_size,
  output logic [31:0] mem_l15_address,
  output logic [31:0] mem_l15_data,
  output logic        mem_l15_val,
  input  logic        l15_mem_header_ack,
  input  logic        l15_mem_val,
  input  logic [63:0] l15_mem_data_0,
  input  logic [63:0] l15_mem_data_1,
  input  logic [3:0]  l15_mem_returntype,
  output logic        mem_l15_req_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [3:0]  rqtype_q, rqtype_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] address_q, address_d;
  logic [31:0] data_q, data_d;
  logic [63:0] rdata0_q, rdata0_d;
  logic [63:0] rdata1_q, rdata1_d;
  logic [3:0]  rtype_q, rtype_d;
  logic        resp0_val_q, resp0_val_d;
  logic        resp1_val_q, resp1_val_d;
  logic        timeout_err_q, timeout_err_d;
  logic        err_port_q, err_port_d;

  logic any_req;
  logic sel;
  logic grant;
  logic rsp_done;
  logic wd_expired;
  logic abort;

  always_comb begin
    any_req  = req0_val | req1_val;
    // On a tie the port that did not win last time goes next.
    sel      = (req0_val & req1_val) ? ~last_q : req1_val;
    grant    = (state_q == ST_IDLE) & any_req & ~nrst;
    rsp_done = (state_q == ST_WAIT) & l15_mem_val;
    // >= rather than ==: an ack on the last REQ cycle carries an exhausted budget into WAIT.
    wd_expired = (wd_q >= WD_LAST);
    abort      = wd_expired &
                 (((state_q == ST_REQ)  & ~l15_mem_header_ack) |
                  ((state_q == ST_WAIT) & ~l15_mem_val));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (l15_mem_header_ack) state_d = ST_WAIT;
        else if (wd_expired)    state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (l15_mem_val)     state_d = ST_IDLE;
        else if (wd_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req0_grant      = grant & ~sel;
    req1_grant      = grant & sel;
    mem_l15_val     = (state_q == ST_REQ);
    mem_l15_req_ack = rsp_done;
    busy            = (state_q != ST_IDLE);
  end

  always_comb begin
    last_d        = last_q;
    owner_d       = owner_q;
    wd_d          = wd_q;
    rqtype_d      = rqtype_q;
    size_d        = size_q;
    address_d     = address_q;
    data_d        = data_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    rtype_d       = rtype_q;
    resp0_val_d   = rsp_done & ~owner_q;
    resp1_val_d   = rsp_done & owner_q;
    timeout_err_d = abort;
    err_port_d    = abort & owner_q;

    if (grant) begin
      last_d    = sel;
      owner_d   = sel;
      wd_d      = '0;
      rqtype_d  = sel ? req1_rqtype  : req0_rqtype;
      size_d    = sel ? req1_size    : req0_size;
      address_d = sel ? req1_address : req0_address;
      data_d    = sel ? req1_data    : req0_data;
    end else if (state_q != ST_IDLE) begin
      wd_d = wd_q + 1'b1;
    end

    if (rsp_done) begin
      rdata0_d = l15_mem_data_0;
      rdata1_d = l15_mem_data_1;
      rtype_d  = l15_mem_returntype;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      wd_q          <= '0;
      rqtype_q      <= '0;
      size_q        <= '0;
      address_q     <= '0;
      data_q        <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      rtype_q       <= '0;
      resp0_val_q   <= 1'b0;
      resp1_val_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      err_port_q    <= 1'b0;
    end else begin
      last_q        <= last_d;
      owner_q       <= owner_d;
      wd_q          <= wd_d;
      rqtype_q      <= rqtype_d;
      size_q        <= size_d;
      address_q     <= address_d;
      data_q        <= data_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      rtype_q       <= rtype_d;
      resp0_val_q   <= resp0_val_d;
      resp1_val_q   <= resp1_val_d;
      timeout_err_q <= timeout_err_d;
      err_port_q    <= err_port_d;
    end
  end

  assign mem_l15_rqtype  = rqtype_q;
  assign mem_l15_size    = size_q;
  assign mem_l15_address = address_q;
  assign mem_l15_data    = data_q;
  assign resp_data_0     = rdata0_q;
  assign resp_data_1     = rdata1_q;
  assign resp_returntype = rtype_q;
  assign resp0_val       = resp0_val_q;
  assign resp1_val       = resp1_val_q;
  assign timeout_err     = timeout_err_q;
  assign err_port        = err_port_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed bench for l15_req_arbiter: per-cycle vector table plus hand-written timeout/reset sequences.
module tb_l15_req_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req0_val, req1_val;
  logic [3:0]  req0_rqtype, req1_rqtype;
  logic [2:0]  req0_size, req1_size;
  logic [31:0] req0_address, req1_address, req0_data, req1_data;
  logic        req0_grant, req1_grant, resp0_val, resp1_val;
  logic [63:0] resp_data_0, resp_data_1;
  logic [3:0]  resp_returntype;
  logic        timeout_err, err_port, busy;
  logic [3:0]  mem_l15_rqtype;
  logic [2:0]  mem_l15_size;
  logic [31:0] mem_l15_address, mem_l15_data;
  logic        mem_l15_val, l15_mem_header_ack, l15_mem_val, mem_l15_req_ack;
  logic [63:0] l15_mem_data_0, l15_mem_data_1;
  logic [3:0]  l15_mem_returntype;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l15_req_arbiter #(.TIMEOUT(8), .TO_W(4)) dut (
    .clk(clk), .nrst(nrst),
    .req0_val(req0_val), .req0_rqtype(req0_rqtype), .req0_size(req0_size),
    .req0_address(req0_address), .req0_data(req0_data),
    .req0_grant(req0_grant), .resp0_val(resp0_val),
    .req1_val(req1_val), .req1_rqtype(req1_rqtype), .req1_size(req1_size),
    .req1_address(req1_address), .req1_data(req1_data),
    .req1_grant(req1_grant), .resp1_val(resp1_val),
    .resp_data_0(resp_data_0), .resp_data_1(resp_data_1), .resp_returntype(resp_returntype),
    .timeout_err(timeout_err), .err_port(err_port), .busy(busy),
    .mem_l15_rqtype(mem_l15_rqtype), .mem_l15_size(mem_l15_size),
    .mem_l15_address(mem_l15_address), .mem_l15_data(mem_l15_data),
    .mem_l15_val(mem_l15_val), .l15_mem_header_ack(l15_mem_header_ack),
    .l15_mem_val(l15_mem_val), .l15_mem_data_0(l15_mem_data_0),
    .l15_mem_data_1(l15_mem_data_1), .l15_mem_returntype(l15_mem_returntype),
    .mem_l15_req_ack(mem_l15_req_ack)
  );

  // in  = {rst, req0_val, req1_val, header_ack, l15_mem_val}
  // ef  = {req0_grant, req1_grant, mem_l15_val, req_ack, resp0_val, resp1_val, busy, timeout_err}
  typedef struct {
    logic [4:0]  in;
    logic [63:0] d0;
    logic        chk;
    logic [7:0]  ef;
    logic [31:0] ma;
    logic [63:0] rd0;
  } vec_t;

  vec_t tbl[$];
  string fnames[8] = '{"req0_grant", "req1_grant", "mem_l15_val", "mem_l15_req_ack",
                       "resp0_val", "resp1_val", "busy", "timeout_err"};

  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DC = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] DD = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DE = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DF = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] DX = 64'h0BAD_F00D_0000_0070;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response data_1 is the half-swapped data_0 and returntype is data_0[7:4].
  function automatic logic [63:0] swap(input logic [63:0] d);
    return {d[31:0], d[63:32]};
  endfunction

  task automatic apply_in(input logic [4:0] in, input logic [63:0] d0);
    nrst               = in[4];
    req0_val           = in[3];
    req1_val           = in[2];
    l15_mem_header_ack = in[1];
    l15_mem_val        = in[0];
    l15_mem_data_0     = d0;
    l15_mem_data_1     = swap(d0);
    l15_mem_returntype = d0[7:4];
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req_fields();
    req0_rqtype = 4'h1; req0_size = 3'h2; req0_address = 32'h0000_1000; req0_data = 32'hCAFE_0001;
    req1_rqtype = 4'h3; req1_size = 3'h3; req1_address = 32'h0000_2000; req1_data = 32'hCAFE_0002;
  endtask

  task automatic check_row(input int r, input vec_t v);
    logic [7:0] act;
    act = {req0_grant, req1_grant, mem_l15_val, mem_l15_req_ack,
           resp0_val, resp1_val, busy, timeout_err};
    for (int b = 0; b < 8; b++)
      chk($sformatf("row%0d %s", r, fnames[b]), 64'(act[7-b]), 64'(v.ef[7-b]));
    chk($sformatf("row%0d mem_l15_address", r), 64'(mem_l15_address), 64'(v.ma));
    chk($sformatf("row%0d resp_data_0", r), resp_data_0, v.rd0);
    chk($sformatf("row%0d resp_data_1", r), resp_data_1, swap(v.rd0));
    chk($sformatf("row%0d resp_returntype", r), 64'(resp_returntype), 64'(v.rd0[7:4]));
  endtask

  initial begin
    int n;

    // single fetch request, then back-to-back alternation under contention
    tbl.push_back('{5'b10000, 64'h0, 1'b0, 8'b0000_0000, 32'h0,    64'h0});
    tbl.push_back('{5'b01010, 64'h0, 1'b1, 8'b1000_0000, 32'h0,    64'h0});
    tbl.push_back('{5'b00000, 64'h0, 1'b1, 8'b0010_0010, 32'h1000, 64'h0});
    tbl.push_back('{5'b00010, 64'h0, 1'b1, 8'b0010_0010, 32'h1000, 64'h0});
    tbl.push_back('{5'b00001, DA,    1'b1, 8'b0001_0010, 32'h1000, 64'h0});
    tbl.push_back('{5'b00001, DF,    1'b1, 8'b0000_1000, 32'h1000, DA});
    tbl.push_back('{5'b00000, 64'h0, 1'b1, 8'b0000_0000, 32'h1000, DA});
    tbl.push_back('{5'b10000, 64'h0, 1'b0, 8'b0000_0000, 32'h0,    64'h0});
    tbl.push_back('{5'b01100, 64'h0, 1'b1, 8'b1000_0000, 32'h0,    64'h0});
    tbl.push_back('{5'b01110, 64'h0, 1'b1, 8'b0010_0010, 32'h1000, 64'h0});
    tbl.push_back('{5'b01101, DB,    1'b1, 8'b0001_0010, 32'h1000, 64'h0});
    tbl.push_back('{5'b01100, 64'h0, 1'b1, 8'b0100_1000, 32'h1000, DB});
    tbl.push_back('{5'b01110, 64'h0, 1'b1, 8'b0010_0010, 32'h2000, DB});
    tbl.push_back('{5'b01101, DC,    1'b1, 8'b0001_0010, 32'h2000, DB});
    tbl.push_back('{5'b01100, 64'h0, 1'b1, 8'b1000_0100, 32'h2000, DC});
    tbl.push_back('{5'b01110, 64'h0, 1'b1, 8'b0010_0010, 32'h1000, DC});
    tbl.push_back('{5'b01101, DD,    1'b1, 8'b0001_0010, 32'h1000, DC});
    tbl.push_back('{5'b01100, 64'h0, 1'b1, 8'b0100_1000, 32'h1000, DD});
    tbl.push_back('{5'b00010, 64'h0, 1'b1, 8'b0010_0010, 32'h2000, DD});
    tbl.push_back('{5'b00001, DE,    1'b1, 8'b0001_0010, 32'h2000, DD});
    tbl.push_back('{5'b00000, 64'h0, 1'b1, 8'b0000_0100, 32'h2000, DE});

    set_req_fields();
    apply_in(5'b10000, 64'h0);
    cyc();

    foreach (tbl[i]) begin
      apply_in(tbl[i].in, tbl[i].d0);
      @(negedge clk);
      if (tbl[i].chk) check_row(i, tbl[i]);
      cyc();
    end

    // header never acked: port 1 owns, request held 8 cycles, then abort
    apply_in(5'b10000, 64'h0);
    cyc();
    apply_in(5'b00100, 64'h0);
    @(negedge clk);
    chk("to grant1", 64'(req1_grant), 64'd1);
    cyc();
    apply_in(5'b00000, 64'h0);
    req1_address = 32'hFFFF_FFFF; req1_rqtype = 4'hF; req1_size = 3'h7; req1_data = 32'h0;
    @(negedge clk);
    chk("to held address", 64'(mem_l15_address), 64'h2000);
    chk("to held rqtype", 64'(mem_l15_rqtype), 64'h3);
    chk("to held size", 64'(mem_l15_size), 64'h3);
    chk("to held data", 64'(mem_l15_data), 64'hCAFE_0002);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_l15_val) break;
      n++;
      cyc();
      @(negedge clk);
    end
    chk("to req cycles", 64'(n), 64'd8);
    chk("to timeout_err", 64'(timeout_err), 64'd1);
    chk("to err_port", 64'(err_port), 64'd1);
    chk("to busy", 64'(busy), 64'd0);
    chk("to no resp", 64'({resp0_val, resp1_val}), 64'd0);
    cyc();
    @(negedge clk);
    chk("to pulse end", 64'(timeout_err), 64'd0);
    set_req_fields();

    // ack on the last budgeted REQ cycle wins over the timeout
    cyc();
    apply_in(5'b01000, 64'h0);
    @(negedge clk);
    chk("lim grant0", 64'(req0_grant), 64'd1);
    cyc();
    apply_in(5'b00000, 64'h0);
    for (int i = 0; i < 8; i++) begin
      l15_mem_header_ack = (i == 7);
      @(negedge clk);
      chk($sformatf("lim req%0d mem_l15_val", i), 64'(mem_l15_val), 64'd1);
      cyc();
    end
    apply_in(5'b00001, DX);
    @(negedge clk);
    chk("lim wait req_ack", 64'(mem_l15_req_ack), 64'd1);
    chk("lim wait busy", 64'(busy), 64'd1);
    chk("lim wait no timeout", 64'(timeout_err), 64'd0);
    cyc();
    apply_in(5'b00000, 64'h0);
    @(negedge clk);
    chk("lim resp0_val", 64'(resp0_val), 64'd1);
    chk("lim no timeout", 64'(timeout_err), 64'd0);
    chk("lim resp_data_0", resp_data_0, DX);
    chk("lim returntype", 64'(resp_returntype), 64'h7);

    // response never arrives: WAIT runs out the remaining 7 cycles
    cyc();
    apply_in(5'b01000, 64'h0);
    @(negedge clk);
    chk("wto grant0", 64'(req0_grant), 64'd1);
    cyc();
    apply_in(5'b00010, 64'h0);
    cyc();
    apply_in(5'b00000, 64'h0);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      n++;
      cyc();
      @(negedge clk);
    end
    chk("wto wait cycles", 64'(n), 64'd7);
    chk("wto timeout_err", 64'(timeout_err), 64'd1);
    chk("wto err_port", 64'(err_port), 64'd0);
    chk("wto no resp", 64'({resp0_val, resp1_val}), 64'd0);

    // reset while waiting drops the transaction and restores port-0 priority
    cyc();
    apply_in(5'b01000, 64'h0);
    @(negedge clk);
    chk("rst grant0", 64'(req0_grant), 64'd1);
    cyc();
    apply_in(5'b00010, 64'h0);
    cyc();
    apply_in(5'b10000, 64'h0);
    @(negedge clk);
    chk("rst in wait busy", 64'(busy), 64'd1);
    cyc();
    apply_in(5'b00001, DB);
    @(negedge clk);
    chk("rst after busy", 64'(busy), 64'd0);
    chk("rst after mem_l15_val", 64'(mem_l15_val), 64'd0);
    chk("rst late req_ack", 64'(mem_l15_req_ack), 64'd0);
    cyc();
    apply_in(5'b00000, 64'h0);
    @(negedge clk);
    chk("rst no resp", 64'({resp0_val, resp1_val}), 64'd0);
    chk("rst no timeout", 64'(timeout_err), 64'd0);
    chk("rst resp_data_0", resp_data_0, 64'h0);
    cyc();
    apply_in(5'b01100, 64'h0);
    @(negedge clk);
    chk("rst tie grant0", 64'(req0_grant), 64'd1);
    chk("rst tie grant1", 64'(req1_grant), 64'd0);
    cyc();
    apply_in(5'b00000, 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Arbitrates the single OpenPiton L1.5 request/response port between instruction fetch (port 0) and the execute-stage memory wrapper (port 1).
- Sits between both requesters and the L1.5 interface.
- Allows one outstanding transaction at a time: latches the winning request, drives the L1.5 request until header ack, waits for the response, then routes it back to the owner.
- Uses round-robin fairness and a response watchdog.

Parameters:
- TIMEOUT, 255: cycles allowed from request launch to response before abort. Minimum 2.
- TO_W, 8: watchdog counter width. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-high reset (1 = reset)
- req0_val  in  1  fetch request valid
- req0_rqtype  in  4  fetch request type
- req0_size  in  3  fetch access size
- req0_address  in  32  fetch address
- req0_data  in  32  fetch store data (unused, still latched)
- req0_grant  out  1  fetch request accepted this cycle
- resp0_val  out  1  response for fetch valid (1-cycle pulse)
- req1_val, req1_rqtype, req1_size, req1_address, req1_data  in  1/4/3/32/32  memory-wrapper request
- req1_grant  out  1  memory-wrapper request accepted
- resp1_val  out  1  response for memory wrapper valid (1-cycle pulse)
- resp_data_0  out  64  captured l15_mem_data_0
- resp_data_1  out  64  captured l15_mem_data_1
- resp_returntype  out  4  captured l15_mem_returntype
- timeout_err  out  1  watchdog abort pulse
- err_port  out  1  owner of the aborted transaction
- busy  out  1  arbiter not IDLE
- mem_l15_rqtype  out  4  to L1.5
- mem_l15_size  out  3  to L1.5
- mem_l15_address  out  32  to L1.5
- mem_l15_data  out  32  to L1.5
- mem_l15_val  out  1  to L1.5
- l15_mem_header_ack  in  1  request header accepted
- l15_mem_val  in  1  response valid
- l15_mem_data_0  in  64  response data
- l15_mem_data_1  in  64  response data
- l15_mem_returntype  in  4  response type
- mem_l15_req_ack  out  1  response consumed

Behaviour:
- Reset (nrst=1 at a clk edge): state=IDLE, last=1 (so port 0 wins the first tie), watchdog=0, all latched request fields=0.
  - Every output reads 0 from the following cycle.
  - Reset mid-transaction drops the transaction silently: no resp, no timeout_err.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - sel = port 0 if only req0_val; port 1 if only req1_val; if both, the port != last.
  - reqN_grant = combinational pulse in this same cycle for sel.
  - On that edge: latch sel's rqtype/size/address/data, owner<=sel, last<=sel, watchdog<=0, go to REQ.
  - Requester may drop val or change fields from the next cycle on.
- REQ:
  - mem_l15_val=1; mem_l15_* driven only from latched registers, held stable.
  - On l15_mem_header_ack=1: go to WAIT. mem_l15_val is 0 the next cycle.
  - Header ack outside REQ is ignored.
- WAIT:
  - mem_l15_req_ack = combinational (state==WAIT & l15_mem_val).
  - On l15_mem_val: capture data_0/data_1/returntype into resp regs, go to IDLE.
  - resp{owner}_val pulses on the following cycle, coinciding with the first IDLE cycle, where a new grant may also occur.
  - l15_mem_val outside WAIT: mem_l15_req_ack stays 0 and nothing is captured.
- Watchdog:
  - Increments each cycle in REQ or WAIT; cleared on entering REQ.
  - When it equals TIMEOUT-1 and the exit condition is not met that cycle: go to IDLE, pulse timeout_err with err_port=owner next cycle, no resp_val.
  - An ack and timeout in the same cycle: the ack wins.
- resp_data/resp_returntype hold their last captured value until the next capture.
- busy = (state != IDLE).
- Throughput: minimum 3 cycles per transaction (IDLE, REQ with same-cycle header ack, WAIT with same-cycle response).

Test Plan:
- Reset then req0_val=1 addr=0x0000_1000 alone -> req0_grant=1 that cycle; next cycle mem_l15_val=1, mem_l15_address=0x1000; header_ack next -> val=0.
- Both req0/req1 valid continuously for 4 transactions after reset -> grants alternate 0,1,0,1; each resp routes to the matching respN_val only.
- In WAIT, drive l15_mem_val with data_0=0xDEAD_BEEF_0000_0001, returntype=4'h0 -> mem_l15_req_ack=1 same cycle; next cycle resp1_val=1, resp_data_0=0xDEADBEEF00000001.
- TIMEOUT=8, never assert header_ack -> mem_l15_val high for exactly 8 cycles, then timeout_err=1 with err_port=owner for one cycle, busy=0, no resp pulse.
- Assert nrst=1 for one cycle while in WAIT -> next cycle busy=0 and mem_l15_val=0; a late l15_mem_val gives no req_ack and no resp; first grant afterwards goes to port 0 on tie.
